// File: rtl/dorodon_input_mapper.sv
// -----------------------------------------------------------------------------
// dorodon_input_mapper
// Turns raw HPS input (PS/2 key event word + two joystick words) into the
// active-low, two-player button vectors used by the ladybug-family core.
// Stage 1 registers key state, joysticks and rotate; stage 2 registers the
// merged/remapped/cleaned buttons, so an input change shows up two clk_sys
// edges after it is applied. Coin outputs come from per-slot pulse FSMs.
//
// Optional build macro: INPUT_AUTOFIRE_EN -- joystick bit 8 drives a square
// wave on that player's fire output (half-period AUTOFIRE_DIV cycles).
//
// Ports:
//   clk_sys        system clock
//   reset          synchronous, active-high reset
//   ps2_key[10:0]  [10] event toggle, [9] pressed, [8] extended, [7:0] code
//   joystick_0/1   [0]R [1]L [2]D [3]U [4]fire [5]bomb [6]start [7]coin [8]af
//   rotate         1 = horizontal-screen direction remap
//   but_*_s[1:0]   active-low buttons, [0]=P1/slot1 [1]=P2/slot2
//   but_tilt_s     constant 2'b11
// -----------------------------------------------------------------------------
module dorodon_input_mapper #(
    parameter int COIN_PULSE   = 400000,
    parameter int COIN_GAP     = 400000,
    parameter int AUTOFIRE_DIV = 1000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic [1:0]  but_coin_s,
    output logic [1:0]  but_select_s,
    output logic [1:0]  but_fire_s,
    output logic [1:0]  but_bomb_s,
    output logic [1:0]  but_up_s,
    output logic [1:0]  but_down_s,
    output logic [1:0]  but_left_s,
    output logic [1:0]  but_right_s,
    output logic [1:0]  but_tilt_s
);

`ifdef INPUT_AUTOFIRE_EN
    localparam int JW = 9;
`else
    localparam int JW = 8;
`endif
    localparam int CMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_st_t;

    // Key register slots: 0-5 P1 U/D/L/R/fire/bomb, 6-11 same for P2,
    // 12/13 start P1 (05,16), 14/15 start P2 (06,1E), 16/17 coin slots.
    logic [17:0]    r_keys;
    logic           r_tog;
    logic [JW-1:0]  r_joy0, r_joy1;
    logic           r_rot;
    logic [1:0]     r_up, r_dn, r_lf, r_rt, r_fire, r_bomb, r_sel;
    logic [1:0]     r_req_prev;
    coin_st_t       r_cst [2];
    coin_st_t       w_cst [2];
    logic [CW-1:0]  r_ccnt [2];
    logic [CW-1:0]  w_ccnt [2];

    logic           w_hit;
    logic [4:0]     w_idx;
    logic [1:0]     w_u, w_d, w_l, w_r, w_ru, w_rd, w_rl, w_rr;
    logic [1:0]     w_fire, w_fire_all, w_bomb, w_sel, w_req;
    logic           w_unused_bits;

    always_comb begin
        w_hit = 1'b1;
        w_idx = 5'd0;
        case (ps2_key[7:0])
            8'h75: w_idx = 5'd0;
            8'h72: w_idx = 5'd1;
            8'h6B: w_idx = 5'd2;
            8'h74: w_idx = 5'd3;
            8'h14: w_idx = 5'd4;
            8'h29: w_idx = 5'd5;
            8'h2D: w_idx = 5'd6;
            8'h2B: w_idx = 5'd7;
            8'h23: w_idx = 5'd8;
            8'h34: w_idx = 5'd9;
            8'h1C: w_idx = 5'd10;
            8'h1B: w_idx = 5'd11;
            8'h05: w_idx = 5'd12;
            8'h16: w_idx = 5'd13;
            8'h06: w_idx = 5'd14;
            8'h1E: w_idx = 5'd15;
            8'h2E: w_idx = 5'd16;
            8'h36: w_idx = 5'd17;
            default: w_hit = 1'b0;
        endcase
    end

    assign w_u    = {r_keys[6]  | r_joy1[3], r_keys[0] | r_joy0[3]};
    assign w_d    = {r_keys[7]  | r_joy1[2], r_keys[1] | r_joy0[2]};
    assign w_l    = {r_keys[8]  | r_joy1[1], r_keys[2] | r_joy0[1]};
    assign w_r    = {r_keys[9]  | r_joy1[0], r_keys[3] | r_joy0[0]};
    assign w_fire = {r_keys[10] | r_joy1[4], r_keys[4] | r_joy0[4]};
    assign w_bomb = {r_keys[11] | r_joy1[5], r_keys[5] | r_joy0[5]};
    assign w_sel  = {r_keys[14] | r_keys[15] | r_joy1[6],
                     r_keys[12] | r_keys[13] | r_joy0[6]};
    assign w_req  = {r_keys[17] | r_joy1[7], r_keys[16] | r_joy0[7]};

    // Horizontal-screen remap happens before cleaning so that the cleaned
    // pairs are the ones the core actually sees.
    assign w_ru = r_rot ? w_l : w_u;
    assign w_rd = r_rot ? w_r : w_d;
    assign w_rl = r_rot ? w_d : w_l;
    assign w_rr = r_rot ? w_u : w_r;

`ifdef INPUT_AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_DIV + 1);
    logic [1:0][AW-1:0] r_af_cnt;
    logic [1:0]         r_af_ph;
    logic [1:0]         w_af_held;

    assign w_af_held = {r_joy1[8], r_joy0[8]};

    // Phase 0 = fire active, so the wave starts active on the first held cycle.
    always_ff @(posedge clk_sys) begin
        for (int p = 0; p < 2; p++) begin
            if (reset || !w_af_held[p]) begin
                r_af_cnt[p] <= '0;
                r_af_ph[p]  <= 1'b0;
            end else if (r_af_cnt[p] == AW'(AUTOFIRE_DIV - 1)) begin
                r_af_cnt[p] <= '0;
                r_af_ph[p]  <= ~r_af_ph[p];
            end else begin
                r_af_cnt[p] <= r_af_cnt[p] + 1'b1;
            end
        end
    end

    assign w_fire_all    = w_fire | (w_af_held & ~r_af_ph);
    assign w_unused_bits = ^{ps2_key[8], joystick_0[15:9], joystick_1[15:9]};
`else
    assign w_fire_all    = w_fire;
    assign w_unused_bits = ^{ps2_key[8], joystick_0[15:8], joystick_1[15:8]};
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_tog      <= ps2_key[10];
            r_keys     <= '0;
            r_joy0     <= '0;
            r_joy1     <= '0;
            r_rot      <= 1'b0;
            r_up       <= 2'b11;
            r_dn       <= 2'b11;
            r_lf       <= 2'b11;
            r_rt       <= 2'b11;
            r_fire     <= 2'b11;
            r_bomb     <= 2'b11;
            r_sel      <= 2'b11;
            r_req_prev <= 2'b00;
        end else begin
            if (ps2_key[10] != r_tog) begin
                r_tog <= ps2_key[10];
                if (w_hit) r_keys[w_idx] <= ps2_key[9];
            end
            r_joy0     <= joystick_0[JW-1:0];
            r_joy1     <= joystick_1[JW-1:0];
            r_rot      <= rotate;
            r_up       <= ~(w_ru & ~w_rd);
            r_dn       <= ~(w_rd & ~w_ru);
            r_lf       <= ~(w_rl & ~w_rr);
            r_rt       <= ~(w_rr & ~w_rl);
            r_fire     <= ~w_fire_all;
            r_bomb     <= ~w_bomb;
            r_sel      <= ~w_sel;
            r_req_prev <= w_req;
        end
    end

    // Coin FSMs: one pulse per accepted request edge; edges seen outside
    // IDLE are dropped rather than queued.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_cst[s]  = r_cst[s];
            w_ccnt[s] = r_ccnt[s];
            case (r_cst[s])
                C_IDLE: begin
                    if (w_req[s] && !r_req_prev[s]) begin
                        w_cst[s]  = C_PULSE;
                        w_ccnt[s] = '0;
                    end
                end
                C_PULSE: begin
                    if (r_ccnt[s] == CW'(COIN_PULSE - 1)) begin
                        w_cst[s]  = C_GAP;
                        w_ccnt[s] = '0;
                    end else begin
                        w_ccnt[s] = r_ccnt[s] + 1'b1;
                    end
                end
                C_GAP: begin
                    if (r_ccnt[s] == CW'(COIN_GAP - 1)) begin
                        w_cst[s]  = C_IDLE;
                        w_ccnt[s] = '0;
                    end else begin
                        w_ccnt[s] = r_ccnt[s] + 1'b1;
                    end
                end
                default: begin
                    w_cst[s]  = C_IDLE;
                    w_ccnt[s] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                r_cst[s]  <= C_IDLE;
                r_ccnt[s] <= '0;
            end else begin
                r_cst[s]  <= w_cst[s];
                r_ccnt[s] <= w_ccnt[s];
            end
        end
    end

    assign but_coin_s   = {r_cst[1] != C_PULSE, r_cst[0] != C_PULSE};
    assign but_select_s = r_sel;
    assign but_fire_s   = r_fire;
    assign but_bomb_s   = r_bomb;
    assign but_up_s     = r_up;
    assign but_down_s   = r_dn;
    assign but_left_s   = r_lf;
    assign but_right_s  = r_rt;
    assign but_tilt_s   = 2'b11;

endmodule

// File: doc/dorodon_input_mapper.md
Name: dorodon_input_mapper

Overview:
- Converts raw HPS user input into the active-low, two-player button vectors consumed by the ladybug-family game core.
- Raw inputs are the PS/2 key event word and two 16-bit joystick words.
- Sits between hps_io and the core.
- Performs the following, all registered on clk_sys:
  - key-state tracking
  - joystick merge
  - orientation remap
  - opposite-direction cleaning
  - coin pulse shaping

Parameters:
COIN_PULSE, 400000, coin output active length in clk_sys cycles (min 1)
COIN_GAP, 400000, lockout cycles after a coin pulse before a new coin edge is accepted (min 1)
AUTOFIRE_DIV, 1000000, half-period of autofire toggle in cycles (used only with INPUT_AUTOFIRE_EN)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
joystick_0  in  16  player 1: [0]R [1]L [2]D [3]U [4]fire [5]bomb [6]start [7]coin [8]autofire
joystick_1  in  16  player 2, same layout
rotate  in  1  1 = horizontal-screen remap of directions
but_coin_s  out  2  active-low coin, [0]=slot1 [1]=slot2
but_select_s  out  2  active-low start 1P/2P
but_fire_s, but_bomb_s  out  2 each  active-low, [0]=P1 [1]=P2
but_up_s, but_down_s, but_left_s, but_right_s  out  2 each  active-low per player
but_tilt_s  out  2  constant 2'b11

Behaviour:
- Reset:
  - All key-state registers clear.
  - Toggle capture register loads ps2_key[10], so no spurious event is seen on release.
  - Coin FSMs go to IDLE and counters clear.
  - Every output goes to 2'b11.
- Key events:
  - An event occurs on the edge where ps2_key[10] != captured toggle.
  - On that edge the capture register updates, and the matching key register loads ps2_key[9].
  - The extended bit is ignored.
  - Unmapped codes cause no change.
- Key map (scancode):
  - P1: 75 up, 72 down, 6B left, 74 right, 14 fire, 29 bomb.
  - P2: 2D up, 2B down, 23 left, 34 right, 1C fire, 1B bomb.
  - Start: 05 and 16 start P1; 06 and 1E start P2.
  - Coin: 2E coin slot1, 36 coin slot2.
- Latency: an output reflects a ps2_key or joystick change 2 clk_sys edges after the change is applied.
- Per-player raw direction = key OR joystick bit.
- Rotate remap:
  - rotate=1: up<-left, down<-right, left<-down, right<-up.
  - rotate=0: pass-through.
  - Remap is applied before cleaning.
- Opposite-direction cleaning: if up and down are both asserted, neither is output; the same applies to left and right.
- Fire/bomb/start: key OR joystick bit; start P1 = key 05|16 | joystick_0[6].
- Coin FSM, one per slot; request = slot key | joystick_n[7]:
  - IDLE: a rising edge of the request (registered previous value 0, current 1) moves to PULSE with the counter cleared; the output is active from the next edge.
  - PULSE: output active for exactly COIN_PULSE cycles, then enter GAP.
  - GAP: output inactive for COIN_GAP cycles, then return to IDLE.
  - Request edges during PULSE or GAP are discarded, not queued.
  - A request held high produces exactly one pulse.
  - Counter width is clog2 of max(COIN_PULSE, COIN_GAP) + 1.
- Slots are independent; simultaneous edges on both slots pulse both in the same cycle.
- Reset asserted mid-pulse: output goes to 1 on the next edge and the FSM returns to IDLE.
- Simultaneous key event and joystick change in one cycle: both take effect together.

Optional Feature:
- Macro INPUT_AUTOFIRE_EN.
- When defined, per player, while joystick_n[8] is held:
  - fire output is driven by a square wave that starts active on the first cycle bit 8 is seen.
  - the wave toggles every AUTOFIRE_DIV cycles and is ORed with normal fire.
  - releasing bit 8 resets the phase counter.
- When not defined: bit 8 is ignored and no autofire counter logic exists.

Test Plan:
- Reset with ps2_key[10]=1: all outputs 2'b11; a following cycle with unchanged ps2_key leaves them 2'b11.
- Toggle ps2_key[10] with {pressed=1, code 0x75}: but_up_s=2'b10 two edges later. Toggle again with pressed=0: returns to 2'b11.
- rotate=1, joystick_0[1]=1: but_up_s[0]=0. Then add joystick_0[0]=1: up and down both asserted, so but_up_s=2'b11 and but_down_s=2'b11.
- COIN_PULSE=4, COIN_GAP=3, key 0x2E held 20 cycles:
  - but_coin_s[0]=0 for exactly 4 cycles, then 1.
  - A re-press during GAP produces no pulse.
  - A re-press after GAP produces a second 4-cycle pulse.
- Coin edges on joystick_0[7] and joystick_1[7] in the same cycle: both bits low for the same 4 cycles. Asserting reset at pulse cycle 2 gives 2'b11 on the next edge.
- With INPUT_AUTOFIRE_EN, AUTOFIRE_DIV=2, joystick_1[8] held: but_fire_s[1] sequence 0,0,1,1,0,0… Without the macro, the same stimulus gives a constant 1.
